// File: rtl/iccm_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported ICCM RAM.
// Grants are combinational; each granted access gets a response exactly one cycle later.
module iccm_arbiter #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            p0_req_i,
   input  logic            p0_we_i,
   input  logic [DW/8-1:0] p0_be_i,
   input  logic [AW-1:0]   p0_addr_i,
   input  logic [DW-1:0]   p0_wdata_i,
   output logic            p0_gnt_o,
   output logic            p0_rvalid_o,
   output logic [DW-1:0]   p0_rdata_o,
   output logic            p0_err_o,
   input  logic            p1_req_i,
   input  logic            p1_we_i,
   input  logic [DW/8-1:0] p1_be_i,
   input  logic [AW-1:0]   p1_addr_i,
   input  logic [DW-1:0]   p1_wdata_i,
   output logic            p1_gnt_o,
   output logic            p1_rvalid_o,
   output logic [DW-1:0]   p1_rdata_o,
   output logic            p1_err_o,
   input  logic            wr_lock_i,
   output logic            ram_en_o,
   output logic [DW/8-1:0] ram_we_o,
   output logic [AW-1:0]   ram_addr_o,
   output logic [DW-1:0]   ram_wdata_o,
   input  logic [DW-1:0]   ram_rdata_i
);
   localparam int BW = DW / 8;

   logic            prio_d, prio_q;
   logic            rsp_valid_d, rsp_valid_q;
   logic            rsp_port_d, rsp_port_q;
   logic            rsp_we_d, rsp_we_q;
   logic            rsp_err_d, rsp_err_q;
   logic            gnt0_s, gnt1_s;
   logic            sel_we_s;
   logic [BW-1:0]   sel_be_s;
   logic [AW-1:0]   sel_addr_s;
   logic [DW-1:0]   sel_wdata_s;

   // Grant selection: a lone requester wins, a tie goes to the port named by prio_q.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (reset) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (p0_req_i && p1_req_i) begin
         if (prio_q) begin
            gnt1_s = 1'b1;
         end else begin
            gnt0_s = 1'b1;
         end
      end else if (p0_req_i) begin
         gnt0_s = 1'b1;
      end else if (p1_req_i) begin
         gnt1_s = 1'b1;
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Route the granted port's request onto the RAM bus; idle bus is all zero.
   always_comb begin
      sel_we_s    = 1'b0;
      sel_be_s    = {BW{1'b0}};
      sel_addr_s  = {AW{1'b0}};
      sel_wdata_s = {DW{1'b0}};
      case ({gnt1_s, gnt0_s})
         2'b01: begin
            sel_we_s    = p0_we_i;
            sel_be_s    = p0_be_i;
            sel_addr_s  = p0_addr_i;
            sel_wdata_s = p0_wdata_i;
         end
         2'b10: begin
            sel_we_s    = p1_we_i;
            sel_be_s    = p1_be_i;
            sel_addr_s  = p1_addr_i;
            sel_wdata_s = p1_wdata_i;
         end
         default: begin
            sel_we_s    = 1'b0;
            sel_be_s    = {BW{1'b0}};
            sel_addr_s  = {AW{1'b0}};
            sel_wdata_s = {DW{1'b0}};
         end
      endcase
   end

   assign p0_gnt_o    = gnt0_s;
   assign p1_gnt_o    = gnt1_s;
   assign ram_en_o    = gnt0_s | gnt1_s;
   assign ram_addr_o  = sel_addr_s;
   assign ram_wdata_o = sel_wdata_s;
   assign ram_we_o    = (sel_we_s && !wr_lock_i) ? sel_be_s : {BW{1'b0}};

   // Next-state: priority passes to the loser; grant info is captured for the response.
   always_comb begin
      prio_d      = prio_q;
      rsp_valid_d = gnt0_s | gnt1_s;
      rsp_port_d  = gnt1_s;
      rsp_we_d    = sel_we_s;
      rsp_err_d   = sel_we_s & wr_lock_i;
      if (gnt0_s) begin
         prio_d = 1'b1;
      end else if (gnt1_s) begin
         prio_d = 1'b0;
      end else begin
         prio_d = prio_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         prio_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_port_q  <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         prio_q      <= prio_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_port_q  <= rsp_port_d;
         rsp_we_q    <= rsp_we_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Steer the response to its port; reset squashes a response still in flight.
   always_comb begin
      p0_rvalid_o = 1'b0;
      p1_rvalid_o = 1'b0;
      p0_err_o    = 1'b0;
      p1_err_o    = 1'b0;
      p0_rdata_o  = {DW{1'b0}};
      p1_rdata_o  = {DW{1'b0}};
      if (rsp_valid_q && !reset) begin
         if (rsp_port_q) begin
            p1_rvalid_o = 1'b1;
            p1_err_o    = rsp_err_q;
            p1_rdata_o  = rsp_we_q ? {DW{1'b0}} : ram_rdata_i;
         end else begin
            p0_rvalid_o = 1'b1;
            p0_err_o    = rsp_err_q;
            p0_rdata_o  = rsp_we_q ? {DW{1'b0}} : ram_rdata_i;
         end
      end else begin
         p0_rvalid_o = 1'b0;
         p1_rvalid_o = 1'b0;
      end
   end

endmodule
